channel_in_acc_sched: RTL and testbench



---
 rtl/channel_in_acc_sched_if.sv | 27 ++
 rtl/channel_in_acc_sched.sv | 109 ++++++++++
 tb/tb_channel_in_acc_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/channel_in_acc_sched_if.sv
// rtl/channel_in_acc_sched_if.sv - handshake/config/status bundle for the channel-in accumulation sequencer
interface channel_in_acc_sched_if #(
   parameter int GROUP_W = 8,
   parameter int PIX_W   = 16
);
   logic               start;
   logic [GROUP_W-1:0] cfg_groups;
   logic [PIX_W-1:0]   cfg_pixels;
   logic               in_valid;
   logic               in_ready;
   logic               acc_first;
   logic               acc_last;
   logic               out_valid;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output start, cfg_groups, cfg_pixels, in_valid,
      input  in_ready, acc_first, acc_last, out_valid, busy, done, err
   );

   modport slave (
      input  start, cfg_groups, cfg_pixels, in_valid,
      output in_ready, acc_first, acc_last, out_valid, busy, done, err
   );
endinterface

// File: rtl/channel_in_acc_sched.sv
// rtl/channel_in_acc_sched.sv - channel-in accumulation sequencer: first/last controls and latency-matched out_valid
// Optional sticky protocol-error detection is built only when ACC_SCHED_ERR_EN is defined.
module channel_in_acc_sched #(
   parameter int LATENCY = 5,
   parameter int GROUP_W = 8,
   parameter int PIX_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   channel_in_acc_sched_if.slave io_acc
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   localparam logic [GROUP_W-1:0] ONE_G = GROUP_W'(1);
   localparam logic [PIX_W-1:0]   ONE_P = PIX_W'(1);

   logic [1:0]         r_state;
   logic [GROUP_W-1:0] r_groups;
   logic [GROUP_W-1:0] r_g;
   logic [PIX_W-1:0]   r_pixels;
   logic [PIX_W-1:0]   r_p;
   logic [LATENCY-1:0] r_vsr;

   logic               w_start_ok;
   logic               w_accept;
   logic               w_grp_last;
   logic               w_acc_last;
   logic [LATENCY-1:0] w_vsr_next;
   logic [GROUP_W-1:0] w_groups_in;

   assign w_start_ok  = (r_state == S_IDLE) && io_acc.start;
   assign w_accept    = io_acc.in_valid && (r_state == S_RUN);
   assign w_grp_last  = (r_g == r_groups - ONE_G);
   assign w_acc_last  = w_accept && w_grp_last;
   assign w_groups_in = (io_acc.cfg_groups == '0) ? ONE_G : io_acc.cfg_groups;
   // DRAIN exits when the register would become empty, so FIN lands the cycle after the last out_valid
   assign w_vsr_next  = (r_vsr << 1) | LATENCY'(w_acc_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_groups <= ONE_G;
         r_g      <= '0;
         r_pixels <= '0;
         r_p      <= '0;
         r_vsr    <= '0;
      end else begin
         r_vsr <= w_vsr_next;
         case (r_state)
            S_IDLE: begin
               if (io_acc.start) begin
                  r_groups <= w_groups_in;
                  r_pixels <= io_acc.cfg_pixels;
                  r_g      <= '0;
                  r_p      <= '0;
                  r_state  <= (io_acc.cfg_pixels == '0) ? S_FIN : S_RUN;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (w_grp_last) begin
                     r_g <= '0;
                     r_p <= r_p + ONE_P;
                     if (r_p == r_pixels - ONE_P) begin
                        r_state <= S_DRAIN;
                     end
                  end else begin
                     r_g <= r_g + ONE_G;
                  end
               end
            end
            S_DRAIN: begin
               if (w_vsr_next == '0) begin
                  r_state <= S_FIN;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef ACC_SCHED_ERR_EN
   logic r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_start_ok) begin
         r_err <= 1'b0;
      end else if ((r_state != S_IDLE) && (r_state != S_RUN) && io_acc.in_valid) begin
         r_err <= 1'b1;
      end
   end

   assign io_acc.err = r_err;
`else
   assign io_acc.err = 1'b0;
`endif

   assign io_acc.in_ready  = (r_state == S_RUN);
   assign io_acc.acc_first = w_accept && (r_g == '0);
   assign io_acc.acc_last  = w_acc_last;
   assign io_acc.out_valid = r_vsr[LATENCY-1];
   assign io_acc.busy      = (r_state != S_IDLE);
   assign io_acc.done      = (r_state == S_FIN);
endmodule

// File: tb/tb_channel_in_acc_sched.sv
// tb/tb_channel_in_acc_sched.sv - scoreboard bench for channel_in_acc_sched
module tb_channel_in_acc_sched;
   localparam int LAT = 5;
`ifdef ACC_SCHED_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   channel_in_acc_sched_if #(.GROUP_W(8), .PIX_W(16)) acc_if ();

   channel_in_acc_sched #(.LATENCY(LAT), .GROUP_W(8), .PIX_W(16)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_acc (acc_if)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int         q_ov[$];
   int         q_done[$];
   logic [1:0] q_beat[$];

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (acc_if.in_valid && acc_if.in_ready) begin
         if (q_beat.size() == 0) check("beat_unexp", int'(acc_if.in_ready), 0);
         else check("first_last", int'({acc_if.acc_first, acc_if.acc_last}), int'(q_beat.pop_front()));
      end else if (acc_if.acc_first || acc_if.acc_last) begin
         check("fl_no_accept", int'({acc_if.acc_first, acc_if.acc_last}), 0);
      end
      if (acc_if.out_valid) begin
         if (q_ov.size() == 0) check("ov_unexp", int'(acc_if.out_valid), 0);
         else check("ov_cycle", cyc, q_ov.pop_front());
      end
      if (acc_if.done) begin
         if (q_done.size() == 0) check("done_unexp", int'(acc_if.done), 0);
         else check("done_cycle", cyc, q_done.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_queues_empty();
      check("q_beat_left", q_beat.size(), 0);
      check("q_ov_left", q_ov.size(), 0);
      check("q_done_left", q_done.size(), 0);
   endtask

   // Called at #1 after an edge while IDLE; returns at #1 after the first IDLE edge.
   task automatic run_job(input int groups, input int pixels, input int gap, input bit poke, input bit hold);
      int eff, t, c, ng, exp_idle;
      eff = (groups == 0) ? 1 : groups;
      exp_idle = 0;
      acc_if.cfg_groups = 8'(groups);
      acc_if.cfg_pixels = 16'(pixels);
      acc_if.start = 1'b1;
      t = cyc;
      if (pixels == 0) begin
         q_done.push_back(t + 1);
         exp_idle = t + 2;
      end
      step();
      acc_if.start      = 1'b0;
      acc_if.cfg_groups = 8'hAA;
      acc_if.cfg_pixels = 16'h5555;
      check("busy_t1", int'(acc_if.busy), 1);
      check("ready_t1", int'(acc_if.in_ready), int'(pixels != 0));
      check("err_t1", int'(acc_if.err), 0);
      for (int b = 0; b < eff * pixels; b++) begin
         ng = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
         repeat (ng) begin
            acc_if.in_valid = 1'b0;
            step();
         end
         acc_if.in_valid = 1'b1;
         c = cyc;
         q_beat.push_back({(b % eff) == 0, (b % eff) == eff - 1});
         if ((b % eff) == eff - 1) q_ov.push_back(c + LAT);
         if (b == eff * pixels - 1) begin
            q_done.push_back(c + LAT + 1);
            exp_idle = c + LAT + 2;
         end
         if (poke && b == 2) begin
            acc_if.start      = 1'b1;
            acc_if.cfg_groups = 8'd1;
            acc_if.cfg_pixels = 16'd1;
         end
         step();
         acc_if.start = 1'b0;
      end
      acc_if.in_valid = hold;
      if (pixels != 0) check("drain_ready", int'(acc_if.in_ready), 0);
      if (poke) begin
         acc_if.start      = 1'b1;
         acc_if.cfg_groups = 8'd1;
         acc_if.cfg_pixels = 16'd1;
      end
      step();
      acc_if.start    = 1'b0;
      acc_if.in_valid = 1'b0;
      for (int i = 0; i < 64 && acc_if.busy; i++) step();
      check("idle_cycle", cyc, exp_idle);
      check("err_end", int'(acc_if.err), int'(hold && ERR_EN));
      check_queues_empty();
   endtask

   initial begin
      acc_if.start      = 1'b0;
      acc_if.cfg_groups = '0;
      acc_if.cfg_pixels = '0;
      acc_if.in_valid   = 1'b0;
      repeat (3) step();
      check("reset_outs", int'({acc_if.in_ready, acc_if.acc_first, acc_if.acc_last, acc_if.out_valid,
                                acc_if.busy, acc_if.done, acc_if.err}), 0);
      rst_n = 1'b1;
      step();
      check("idle_outs", int'({acc_if.in_ready, acc_if.out_valid, acc_if.busy, acc_if.done}), 0);

      run_job(4, 2, 0, 1'b0, 1'b0);
      run_job(0, 3, 3, 1'b0, 1'b0);
      run_job(5, 0, 0, 1'b0, 1'b0);
      run_job(3, 2, 0, 1'b1, 1'b0);
      run_job(2, 1, 0, 1'b0, 1'b0);
      run_job(2, 2, 0, 1'b0, 1'b1);
      run_job(1, 2, 1, 1'b0, 1'b0);

      // abort mid-RUN after five beats
      acc_if.cfg_groups = 8'd2;
      acc_if.cfg_pixels = 16'd4;
      acc_if.start = 1'b1;
      step();
      acc_if.start = 1'b0;
      for (int b = 0; b < 5; b++) begin
         acc_if.in_valid = 1'b1;
         q_beat.push_back({(b % 2) == 0, (b % 2) == 1});
         if ((b % 2) == 1) q_ov.push_back(cyc + LAT);
         step();
      end
      acc_if.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort_busy", int'(acc_if.busy), 0);
      check("abort_ready", int'(acc_if.in_ready), 0);
      q_ov.delete();
      q_done.delete();
      step();
      rst_n = 1'b1;
      repeat (12) step();
      check("abort_idle", int'(acc_if.busy), 0);
      check_queues_empty();

      run_job(3, 1, 0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
